// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch button path (debouncer and
// button_events both use ms_to_cycles).
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } btn_state_e;

  localparam int unsigned CLK_FREQ_KHZ_DEFAULT = 100_000;

  // kHz * ms = cycles. Returned wide so callers can range-check before
  // narrowing to a 32-bit counter.
  function automatic longint unsigned ms_to_cycles(input longint unsigned khz,
                                                   input longint unsigned ms);
    return khz * ms;
  endfunction

endpackage

// File: rtl/button_events.sv
// Turns one debounced button level into single-cycle event pulses:
// press, release, short click, long press and auto-repeat.
// The release and repeat pulses are named btn_release / btn_repeat because
// plain "release" and "repeat" are reserved words in SystemVerilog.
module button_events
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_FREQ_KHZ = CLK_FREQ_KHZ_DEFAULT,
  parameter int unsigned LONG_MS      = 1000,
  parameter int unsigned REPEAT_MS    = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press,
  output logic btn_release,
  output logic short_click,
  output logic long_press,
  output logic btn_repeat,
  output logic held
);

  localparam longint unsigned LONG_CYC_L   = ms_to_cycles(CLK_FREQ_KHZ, LONG_MS);
  localparam longint unsigned REPEAT_CYC_L = ms_to_cycles(CLK_FREQ_KHZ, REPEAT_MS);
  localparam logic [31:0]     LONG_CYC     = LONG_CYC_L[31:0];
  localparam logic [31:0]     REPEAT_CYC   = REPEAT_CYC_L[31:0];

  // Thresholds must fit the 32-bit counter, and a zero long-press time
  // would make the PRESSED threshold unreachable.
  if (LONG_MS < 1 || LONG_CYC_L >= 64'h1_0000_0000 ||
      REPEAT_CYC_L >= 64'h1_0000_0000) begin : g_bad_param
    $error("button_events: LONG_MS must be >= 1 and cycle counts must fit 32 bits");
  end

  btn_state_e  state_q, state_d;
  logic [31:0] count_q, count_d;
  logic        btn_q;
  logic        press_d, release_d, short_d, long_d, repeat_d, held_d;
  logic        rise, fall;

  assign rise = btn & ~btn_q;
  assign fall = ~btn & btn_q;

  // Next-state / next-output logic; a fall always beats a threshold on the
  // same edge so a release never coincides with long_press or repeat.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A fall here can only follow reset-while-held; ignore it.
        if (rise) begin
          press_d = 1'b1;
          count_d = '0;
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        if (fall) begin
          release_d = 1'b1;
          short_d   = 1'b1;
          count_d   = '0;
          state_d   = IDLE;
        end else if (count_q == LONG_CYC - 32'd1) begin
          long_d  = 1'b1;
          count_d = '0;
          state_d = LONG;
        end else begin
          count_d = count_q + 32'd1;
        end
      end
      LONG: begin
        if (fall) begin
          release_d = 1'b1;
          count_d   = '0;
          state_d   = IDLE;
        end else if (REPEAT_CYC != 32'd0) begin
          if (count_q == REPEAT_CYC - 32'd1) begin
            repeat_d = 1'b1;
            count_d  = '0;
          end else begin
            count_d = count_q + 32'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
    held_d = (state_d != IDLE);
  end

  // State, counter and registered outputs. btn_q tracks btn even in reset so
  // a button held through reset produces no press.
  always_ff @(posedge clk) begin
    btn_q <= btn;
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      press       <= 1'b0;
      btn_release <= 1'b0;
      short_click <= 1'b0;
      long_press  <= 1'b0;
      btn_repeat  <= 1'b0;
      held        <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      press       <= press_d;
      btn_release <= release_d;
      short_click <= short_d;
      long_press  <= long_d;
      btn_repeat  <= repeat_d;
      held        <= held_d;
    end
  end

endmodule

// File: doc/button_events.md
Name: button_events

Overview:
- Consumer end of the debounced-button path. Takes one clean, debounced button level and turns it into single-cycle event pulses: press, release, short click, long press, and auto-repeat.
- Sits between each debouncer output and the stopwatch control FSM. Example use: short click = start/stop; long press = clear; repeat = fast-set.
- One instance per button.

Parameters:
- CLK_FREQ_KHZ, 100_000, clock frequency in kHz.
- LONG_MS, 1000, hold time in ms before long_press fires; must be >= 1.
- REPEAT_MS, 200, auto-repeat period in ms after long_press; 0 disables repeat.
- Derived localparams:
  - LONG_CYC = CLK_FREQ_KHZ*LONG_MS
  - REPEAT_CYC = CLK_FREQ_KHZ*REPEAT_MS
  - Counter width 32 bits. Elaboration error if LONG_CYC or REPEAT_CYC >= 2^32.

Ports:
- clk, input, 1, system clock. Single clock domain.
- rst, input, 1, reset. Synchronous and active-high.
- btn, input, 1, debounced button level, already synchronous to clk; 1 = pressed.
- press, output, 1, one-cycle pulse on a press (rising edge).
- release, output, 1, one-cycle pulse on a release (falling edge).
- short_click, output, 1, one-cycle pulse on a release that occurs before long_press fired.
- long_press, output, 1, one-cycle pulse when the button has been held LONG_CYC cycles.
- repeat, output, 1, one-cycle pulse every REPEAT_CYC cycles after long_press while still held.
- held, output, 1, level; 1 while in PRESSED or LONG.

Behaviour:
- All outputs are registered. Pulse outputs are high for exactly one cycle.
- Internal btn_q register holds the previous sample of btn.
  - rise = btn & ~btn_q
  - fall = ~btn & btn_q
- Reset (rst=1 at a posedge):
  - state <= IDLE, count <= 0, all outputs <= 0.
  - btn_q <= btn, so a button held through reset produces no press. It must be released and re-pressed.
- States: IDLE, PRESSED, LONG (encoding from the shared package).
- IDLE:
  - On rise: press <= 1, count <= 0, state <= PRESSED.
  - Otherwise hold.
  - fall in IDLE is ignored; it can only follow reset-while-held.
- PRESSED:
  - On fall: release <= 1, short_click <= 1, state <= IDLE, count <= 0.
  - Else if count == LONG_CYC-1: long_press <= 1, count <= 0, state <= LONG.
  - Else count <= count+1.
- LONG:
  - On fall: release <= 1, state <= IDLE, count <= 0. No short_click.
  - Else if REPEAT_CYC != 0 and count == REPEAT_CYC-1: repeat <= 1, count <= 0.
  - Else if REPEAT_CYC != 0: count <= count+1.
  - If REPEAT_CYC == 0, count stays 0 and repeat never fires.
- held <= 1 when the next state is PRESSED or LONG, else 0. It rises in the same cycle as press and falls in the same cycle as release.
- Timing, with press asserted after edge k:
  - long_press is asserted after edge k+LONG_CYC.
  - The n-th repeat is asserted after edge k+LONG_CYC+n*REPEAT_CYC.
- Simultaneous events: fall wins over any threshold on the same edge.
  - Release at the long-press threshold edge gives release+short_click; no long_press.
  - Release at a repeat threshold edge gives release only; no repeat.
- Mutual exclusion: press never coincides with any other pulse. A 1-cycle btn glitch 0->1->0 yields press, then release+short_click on the next cycle.
- rst mid-hold: returns to IDLE with no release pulse. The button must be released and pressed again to generate events.
- No wrap-around: count is always cleared at its threshold and cannot overflow.

Decomposition:
- Shared package stopwatch_pkg:
  - button state enum (IDLE=0, PRESSED=1, LONG=2, 2-bit)
  - constant CLK_FREQ_KHZ_DEFAULT = 100_000
  - function ms_to_cycles(khz, ms), used by this block and the debouncer
- No sub-module. Edge detect and counter are too small to split; a single module of roughly 150 lines.

Test Plan:
All scenarios use CLK_FREQ_KHZ=1, LONG_MS=10, REPEAT_MS=4, so LONG_CYC=10 and REPEAT_CYC=4.
- Short click: btn rises at edge k, falls at edge k+5 -> press after k; held high k..k+4; release and short_click after k+5; no long_press.
- Long hold: btn high from edge k through k+20 -> long_press after k+10; repeat after k+14 and k+18; release (no short_click) after the fall edge.
- Boundary: btn falls exactly at edge k+10 -> release+short_click after k+10; long_press never asserted. Repeat with fall at k+14 -> release, no repeat.
- Reset while held: assert rst with btn=1, deassert, keep btn=1 for 30 cycles -> no outputs. Then drop and raise btn -> normal press.
- Reset mid-LONG: rst pulse at k+12 -> all outputs 0, held=0, no release; re-press -> long_press exactly 10 cycles after the new press.
- REPEAT_MS=0: hold 40 cycles -> exactly one long_press, zero repeat pulses.
